data_sram_resp: RTL and testbench
=================================

# data_sram_resp

Responder side of the core's data SRAM port: accepts the per-cycle `we/addr/wdata` request the multi-cycle core drives and returns read data one cycle later, as a synchronous SRAM would. Requests are decoded into a word-addressed RAM region and a small confreg peripheral window containing LED, switch, timer and number-display registers. It sits between `mycpu_top`'s `data_sram_*` pins and the SoC/testbench, and replaces the bare RAM model on that port.

## Interface
- `ADDR_W`, default 16: RAM word-index width; RAM depth is 2^ADDR_W words.
- `CONF_BASE`, default 16'hbfaf: value of `sram_addr[31:16]` that selects the confreg window.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `sram_we`  in  1: write strobe for the current cycle's request.
- `sram_addr`  in  32: byte address; bits [1:0] ignored.
- `sram_wdata`  in  32: write data, full word.
- `sram_rdata`  out  32: read data for the address presented in the previous cycle.
- `switch`  in  8: board switch levels, sampled for reads.
- `led`  out  16: LED register.
- `num_data`  out  32: number-display register.

## Operation
- Every cycle is a request; there is no valid/enable. A read is implied whenever `sram_we`=0, and also happens when `sram_we`=1.
- Decode: if `sram_addr[31:16]`==CONF_BASE, the request goes to confreg with offset `sram_addr[15:0]`; otherwise it goes to RAM.
- RAM:
  - Word index is `sram_addr[ADDR_W+1:2]`; higher bits are ignored, so the address space wraps.
  - Contents are not reset.
- Confreg offsets:
  - 0xf000 LED: read/write; bits [15:0] only; read returns {16'b0, led}.
  - 0xf020 SWITCH: read-only; read returns {24'b0, switch}; writes are dropped.
  - 0xe000 TIMER: read/write 32-bit.
    - Increments by 1 every cycle when not in reset, wrapping 0xffffffff→0.
    - A write loads `sram_wdata`, which replaces the increment for that cycle.
  - 0xf100 NUM: read/write 32-bit; drives `num_data`.
  - Any other offset reads 32'b0; writes are dropped.
- Read-first semantics: `sram_rdata` reflects state before the writes of the same edge. This applies to RAM and to all confreg registers, including TIMER.
- A request in a cycle where `reset`=1 performs no write.

## Timing
- Read latency is 1 cycle: the request at edge N is visible on `sram_rdata` after edge N+1 and is held until edge N+2.
- Write latency: the new value is stored at the request edge and is readable by a request issued on the following cycle.
- Reset values: `sram_rdata`=0, `led`=16'h0000, `num_data`=0, TIMER=0.
- Reset mid-operation:
  - Registers return to their reset values on the edge where `reset`=1.
  - A read in flight is discarded, so `rdata`=0.
  - RAM contents are kept.
- TIMER on the first cycle after reset deasserts: it reads 0 and then counts 1, 2, ….
- Write and increment on the same edge: the write wins, and the count resumes from the written value+1 on the next edge.
- Back-to-back requests to different regions need no bubble. `sram_rdata` selects its source from a registered copy of the region/offset decode.

## Test plan
- RAM write/read:
  - Stimulus: write 0xdeadbeef at 0x1c000100, then read 0x1c000100.
  - Required: `sram_rdata`=0xdeadbeef one cycle after the read.
  - Stimulus: read 0x1c000102.
  - Required: also 0xdeadbeef (bits [1:0] ignored).
- Read-first:
  - Stimulus: at a RAM word holding 0x11111111, issue a read with a simultaneous write of 0x22222222.
  - Required: `rdata`=0x11111111; a read on the next cycle returns 0x22222222.
- Wrap:
  - Stimulus: with ADDR_W=16, write 0x5a5a5a5a at 0x00000040, then read 0x00040040.
  - Required: `rdata`=0x5a5a5a5a.
- Confreg:
  - Stimulus: write 0x0001abcd to 0xbfaff000.
  - Required: `led`=16'habcd from the next cycle; a read returns 0x0000abcd.
  - Stimulus: set `switch`=8'h3c, then read 0xbfaff020.
  - Required: 0x0000003c.
  - Stimulus: write to 0xbfaff020.
  - Required: no effect.
- Timer:
  - Stimulus: write 0xfffffffe to 0xbfafe000, then read it on the next two consecutive cycles.
  - Required: reads return 0xfffffffe and 0xffffffff; a third read returns 0x00000000.
- Reset mid-operation:
  - Stimulus: set NUM=0x12345678, then assert `reset` for 1 cycle during a read of a RAM word holding 0x77.
  - Required: `sram_rdata`=0, `num_data`=0, `led`=0 and TIMER restarts from 0; the RAM word still reads 0x77 afterward.

Source files
------------

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM port responder: word RAM plus LED/switch/timer/number confreg window
// Read data appears one cycle after the request; all reads see state from before that edge's writes.
module data_sram_resp #(
    parameter int          ADDR_W    = 16,
    parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_SWITCH = 16'hf020;
    localparam logic [15:0] OFF_TIMER  = 16'he000;
    localparam logic [15:0] OFF_NUM    = 16'hf100;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_CONF = 2'd2
    } src_t;

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] word_idx;
    logic [15:0]       offset;
    logic              conf_sel;
    logic              wr_en;
    logic [31:0]       timer;
    logic [31:0]       conf_rd;
    logic [31:0]       ram_rdata_q;
    logic [31:0]       conf_rdata_q;
    src_t              src_q;
    logic              unused_addr_lsb;

    assign word_idx        = sram_addr[ADDR_W+1:2];
    assign offset          = sram_addr[15:0];
    assign conf_sel        = (sram_addr[31:16] == CONF_BASE);
    assign wr_en           = sram_we && !reset;
    assign unused_addr_lsb = ^sram_addr[1:0];

    always_comb begin
        conf_rd = 32'h0;
        case (offset)
            OFF_LED:    conf_rd = {16'h0, led};
            OFF_SWITCH: conf_rd = {24'h0, switch};
            OFF_TIMER:  conf_rd = timer;
            OFF_NUM:    conf_rd = num_data;
            default:    conf_rd = 32'h0;
        endcase
    end

    // RAM holds its contents through reset, so it has no reset branch.
    always_ff @(posedge clk) begin
        ram_rdata_q <= mem[word_idx];
        if (wr_en && !conf_sel) begin
            mem[word_idx] <= sram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led          <= 16'h0;
            num_data     <= 32'h0;
            timer        <= 32'h0;
            conf_rdata_q <= 32'h0;
            src_q        <= SRC_NONE;
        end else begin
            conf_rdata_q <= conf_rd;
            src_q        <= conf_sel ? SRC_CONF : SRC_RAM;
            if (wr_en && conf_sel && offset == OFF_TIMER) begin
                timer <= sram_wdata;
            end else begin
                timer <= timer + 32'd1;
            end
            if (wr_en && conf_sel && offset == OFF_LED) begin
                led <= sram_wdata[15:0];
            end
            if (wr_en && conf_sel && offset == OFF_NUM) begin
                num_data <= sram_wdata;
            end
        end
    end

    // Source is chosen from the registered decode so mixed-region streams need no bubble.
    always_comb begin
        case (src_q)
            SRC_RAM:  sram_rdata = ram_rdata_q;
            SRC_CONF: sram_rdata = conf_rdata_q;
            default:  sram_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - directed self-checking bench for data_sram_resp
module tb_data_sram_resp;

    logic        clk;
    logic        reset;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;

    int checks   = 0;
    int failures = 0;

    data_sram_resp #(.ADDR_W(16), .CONF_BASE(16'hbfaf)) dut (
        .clk        (clk),
        .reset      (reset),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .switch     (switch),
        .led        (led),
        .num_data   (num_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        sram_we    = we;
        sram_addr  = addr;
        sram_wdata = wdata;
        tick();
        sram_we    = 1'b0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        sram_we    = 1'b0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        switch     = 8'h00;
        tick();
        tick();
        check("reset_rdata", sram_rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_num", num_data, 32'h0);
        reset = 1'b0;

        req(1'b1, 32'h1c000100, 32'hdeadbeef);
        req(1'b0, 32'h1c000100, 32'h0);
        check("ram_rd", sram_rdata, 32'hdeadbeef);
        req(1'b0, 32'h1c000102, 32'h0);
        check("ram_rd_lsb", sram_rdata, 32'hdeadbeef);

        req(1'b1, 32'h1c000200, 32'h11111111);
        req(1'b1, 32'h1c000200, 32'h22222222);
        check("read_first_old", sram_rdata, 32'h11111111);
        req(1'b0, 32'h1c000200, 32'h0);
        check("read_first_new", sram_rdata, 32'h22222222);

        req(1'b1, 32'h00000040, 32'h5a5a5a5a);
        req(1'b0, 32'h00040040, 32'h0);
        check("wrap", sram_rdata, 32'h5a5a5a5a);

        req(1'b1, 32'hbfaff000, 32'h0001abcd);
        check("led_out", {16'h0, led}, 32'h0000abcd);
        req(1'b0, 32'hbfaff000, 32'h0);
        check("led_rd", sram_rdata, 32'h0000abcd);

        switch = 8'h3c;
        req(1'b0, 32'hbfaff020, 32'h0);
        check("switch_rd", sram_rdata, 32'h0000003c);
        req(1'b1, 32'hbfaff020, 32'hffffffff);
        req(1'b0, 32'hbfaff020, 32'h0);
        check("switch_wr_drop", sram_rdata, 32'h0000003c);
        check("switch_wr_led", {16'h0, led}, 32'h0000abcd);

        req(1'b1, 32'hbfaf1234, 32'hcafef00d);
        req(1'b0, 32'hbfaf1234, 32'h0);
        check("unmapped_rd", sram_rdata, 32'h0);

        // back-to-back RAM then confreg reads
        req(1'b0, 32'h1c000100, 32'h0);
        check("b2b_ram", sram_rdata, 32'hdeadbeef);
        req(1'b0, 32'hbfaff000, 32'h0);
        check("b2b_conf", sram_rdata, 32'h0000abcd);

        req(1'b1, 32'hbfafe000, 32'hfffffffe);
        req(1'b0, 32'hbfafe000, 32'h0);
        check("timer_0", sram_rdata, 32'hfffffffe);
        req(1'b0, 32'hbfafe000, 32'h0);
        check("timer_1", sram_rdata, 32'hffffffff);
        req(1'b0, 32'hbfafe000, 32'h0);
        check("timer_wrap", sram_rdata, 32'h0);

        req(1'b1, 32'hbfaff100, 32'h12345678);
        check("num_out", num_data, 32'h12345678);
        req(1'b0, 32'hbfaff100, 32'h0);
        check("num_rd", sram_rdata, 32'h12345678);
        req(1'b1, 32'h00000300, 32'h00000077);

        reset = 1'b1;
        req(1'b0, 32'h00000300, 32'h0);
        reset = 1'b0;
        check("rst_rdata", sram_rdata, 32'h0);
        check("rst_num", num_data, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        req(1'b0, 32'hbfafe000, 32'h0);
        check("rst_timer_0", sram_rdata, 32'h0);
        req(1'b0, 32'hbfafe000, 32'h0);
        check("rst_timer_1", sram_rdata, 32'h1);
        req(1'b0, 32'hbfafe000, 32'h0);
        check("rst_timer_2", sram_rdata, 32'h2);
        req(1'b0, 32'h00000300, 32'h0);
        check("rst_ram_kept", sram_rdata, 32'h00000077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
